// File: rtl/core_peripheral_pkg.sv
// Shared encodings for the core peripheral responder: command codes from the
// core, response codes back to it, and the responder FSM states.
package core_peripheral_pkg;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_READ  = 2'b10,
    CMD_RSVD  = 2'b11
  } cmd_t;

  typedef enum logic [1:0] {
    RSP_NONE    = 2'b00,
    RSP_WR_ACK  = 2'b01,
    RSP_RD_DATA = 2'b10,
    RSP_ERROR   = 2'b11
  } rsp_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAIT_WR = 2'b01,
    WAIT_RD = 2'b10,
    RESP    = 2'b11
  } state_t;

endpackage

// File: rtl/peripheral_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers.
// A push on a full FIFO is accepted only when a pop frees the slot in the same cycle.
module peripheral_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_BITS = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] head
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_BITS:0]   wr_ptr_reg;
  logic [DEPTH_BITS:0]   rd_ptr_reg;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[DEPTH_BITS] != rd_ptr_reg[DEPTH_BITS]) &&
                   (wr_ptr_reg[DEPTH_BITS-1:0] == rd_ptr_reg[DEPTH_BITS-1:0]);
  // Pop is qualified on the current occupancy, so a push into an empty FIFO
  // only becomes visible (and poppable) on the following cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_reg[DEPTH_BITS-1:0]] <= push_data;
  end

  assign head = mem[rd_ptr_reg[DEPTH_BITS-1:0]];

endmodule

// File: rtl/core_peripheral_responder.sv
// Responder for the core peripheral port: buffers core writes toward the host,
// serves core reads from host data, one registered response per command.
module core_peripheral_responder
  import core_peripheral_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int OUT_DEPTH_BITS = 3,
  parameter int IN_DEPTH_BITS  = 3,
  parameter int TIMEOUT        = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            to_peripheral,
  input  logic [DATA_WIDTH-1:0] to_peripheral_data,
  input  logic                  to_peripheral_valid,
  output logic [1:0]            from_peripheral,
  output logic [DATA_WIDTH-1:0] from_peripheral_data,
  output logic                  from_peripheral_valid,
  output logic [DATA_WIDTH-1:0] host_out_data,
  output logic                  host_out_valid,
  input  logic                  host_out_ready,
  input  logic [DATA_WIDTH-1:0] host_in_data,
  input  logic                  host_in_valid,
  output logic                  host_in_ready,
  output logic                  overrun
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_t                state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [CNT_W-1:0]      cnt_inc;
  logic [DATA_WIDTH-1:0] wr_latch_reg;
  cmd_t                  cmd;
  logic                  cmd_fire;

  logic                  out_full;
  logic                  out_empty;
  logic [DATA_WIDTH-1:0] out_head;
  logic                  out_pop;
  logic                  out_space;
  logic                  out_push;
  logic [DATA_WIDTH-1:0] out_push_data;

  logic                  in_full;
  logic                  in_empty;
  logic [DATA_WIDTH-1:0] in_head;
  logic                  in_push;
  logic                  in_pop;
  logic                  timed_out;

  assign cmd      = cmd_t'(to_peripheral);
  assign cmd_fire = to_peripheral_valid && (state_reg == IDLE);
  assign cnt_inc  = cnt_reg + 1'b1;

  // A host pop in the same cycle frees a slot on a full out FIFO.
  assign out_pop       = host_out_ready && !out_empty;
  assign out_space     = !out_full || out_pop;
  assign out_push      = out_space &&
                         ((cmd_fire && (cmd == CMD_WRITE)) || (state_reg == WAIT_WR));
  assign out_push_data = (state_reg == WAIT_WR) ? wr_latch_reg : to_peripheral_data;

  assign in_push = host_in_valid && !in_full;
  assign in_pop  = !in_empty &&
                   ((cmd_fire && (cmd == CMD_READ)) || (state_reg == WAIT_RD));

  assign timed_out = (TIMEOUT != 0) && (cnt_inc == TIMEOUT_CNT);

  assign host_in_ready  = !in_full;
  assign host_out_valid = !out_empty;
  assign host_out_data  = out_empty ? '0 : out_head;

  peripheral_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_BITS (OUT_DEPTH_BITS)
  ) u_out_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (out_push),
    .push_data (out_push_data),
    .pop       (out_pop),
    .full      (out_full),
    .empty     (out_empty),
    .head      (out_head)
  );

  peripheral_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_BITS (IN_DEPTH_BITS)
  ) u_in_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (in_push),
    .push_data (host_in_data),
    .pop       (in_pop),
    .full      (in_full),
    .empty     (in_empty),
    .head      (in_head)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg             <= IDLE;
      cnt_reg               <= '0;
      wr_latch_reg          <= '0;
      from_peripheral       <= RSP_NONE;
      from_peripheral_data  <= '0;
      from_peripheral_valid <= 1'b0;
      overrun               <= 1'b0;
    end else begin
      // Response outputs are only held for the single RESP cycle.
      from_peripheral       <= RSP_NONE;
      from_peripheral_data  <= '0;
      from_peripheral_valid <= 1'b0;

      if (to_peripheral_valid && (state_reg != IDLE)) overrun <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (to_peripheral_valid) begin
            case (cmd)
              CMD_WRITE: begin
                if (out_space) begin
                  state_reg             <= RESP;
                  from_peripheral       <= RSP_WR_ACK;
                  from_peripheral_valid <= 1'b1;
                end else begin
                  wr_latch_reg <= to_peripheral_data;
                  state_reg    <= WAIT_WR;
                end
              end
              CMD_READ: begin
                if (!in_empty) begin
                  state_reg             <= RESP;
                  from_peripheral       <= RSP_RD_DATA;
                  from_peripheral_data  <= in_head;
                  from_peripheral_valid <= 1'b1;
                end else begin
                  cnt_reg   <= '0;
                  state_reg <= WAIT_RD;
                end
              end
              default: begin
                state_reg             <= RESP;
                from_peripheral       <= RSP_ERROR;
                from_peripheral_valid <= 1'b1;
              end
            endcase
          end
        end

        WAIT_WR: begin
          if (out_space) begin
            state_reg             <= RESP;
            from_peripheral       <= RSP_WR_ACK;
            from_peripheral_valid <= 1'b1;
          end
        end

        WAIT_RD: begin
          cnt_reg <= cnt_inc;
          // Data present on the timeout cycle takes priority over the error.
          if (!in_empty) begin
            state_reg             <= RESP;
            from_peripheral       <= RSP_RD_DATA;
            from_peripheral_data  <= in_head;
            from_peripheral_valid <= 1'b1;
          end else if (timed_out) begin
            state_reg             <= RESP;
            from_peripheral       <= RSP_ERROR;
            from_peripheral_valid <= 1'b1;
          end
        end

        RESP: state_reg <= IDLE;

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_peripheral_responder.sv
// Bench for core_peripheral_responder: directed scenarios then random traffic,
// every cycle compared against a queue-based reference model.
module tb_core_peripheral_responder;

  localparam int DW      = 32;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    to_peripheral;
  logic [DW-1:0] to_peripheral_data;
  logic          to_peripheral_valid;
  logic [1:0]    from_peripheral;
  logic [DW-1:0] from_peripheral_data;
  logic          from_peripheral_valid;
  logic [DW-1:0] host_out_data;
  logic          host_out_valid;
  logic          host_out_ready;
  logic [DW-1:0] host_in_data;
  logic          host_in_valid;
  logic          host_in_ready;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  core_peripheral_responder #(
    .DATA_WIDTH     (DW),
    .OUT_DEPTH_BITS (3),
    .IN_DEPTH_BITS  (3),
    .TIMEOUT        (TIMEOUT)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .to_peripheral         (to_peripheral),
    .to_peripheral_data    (to_peripheral_data),
    .to_peripheral_valid   (to_peripheral_valid),
    .from_peripheral       (from_peripheral),
    .from_peripheral_data  (from_peripheral_data),
    .from_peripheral_valid (from_peripheral_valid),
    .host_out_data         (host_out_data),
    .host_out_valid        (host_out_valid),
    .host_out_ready        (host_out_ready),
    .host_in_data          (host_in_data),
    .host_in_valid         (host_in_valid),
    .host_in_ready         (host_in_ready),
    .overrun               (overrun)
  );

  // Reference model: host-facing queues plus what the responder currently owes the core.
  logic [DW-1:0] m_out_q[$];
  logic [DW-1:0] m_in_q[$];
  int            m_pending;   // 0 free, 1 write waiting for room, 2 read waiting for data, 3 answering
  logic [DW-1:0] m_held;
  int            m_waited;
  logic [1:0]    m_code;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_overrun;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_out_q.delete();
    m_in_q.delete();
    m_pending = 0;
    m_held    = '0;
    m_waited  = 0;
    m_code    = 2'b00;
    m_data    = '0;
    m_valid   = 1'b0;
    m_overrun = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] c, input logic v, input logic [DW-1:0] wd,
                            input logic rdy, input logic hv, input logic [DW-1:0] hd);
    bit            out_pop;
    bit            out_room;
    bit            in_have;
    bit            in_push;
    bit            take_in;
    bit            put_out;
    logic [DW-1:0] put_word;
    logic [DW-1:0] in_front;
    logic [1:0]    ncode;
    logic [DW-1:0] ndata;
    bit            nvalid;
    int            npend;
    out_pop  = rdy && (m_out_q.size() > 0);
    out_room = (m_out_q.size() < DEPTH) || out_pop;
    in_have  = (m_in_q.size() > 0);
    in_push  = hv && (m_in_q.size() < DEPTH);
    in_front = in_have ? m_in_q[0] : '0;
    take_in  = 0;
    put_out  = 0;
    put_word = '0;
    ncode    = 2'b00;
    ndata    = '0;
    nvalid   = 0;
    npend    = m_pending;
    if (v && m_pending != 0) m_overrun = 1'b1;
    case (m_pending)
      0: if (v) begin
        if (c == 2'b01) begin
          if (out_room) begin
            put_out = 1; put_word = wd; npend = 3; nvalid = 1; ncode = 2'b01;
          end else begin
            m_held = wd; npend = 1;
          end
        end else if (c == 2'b10) begin
          if (in_have) begin
            take_in = 1; npend = 3; nvalid = 1; ncode = 2'b10; ndata = in_front;
          end else begin
            m_waited = 0; npend = 2;
          end
        end else begin
          npend = 3; nvalid = 1; ncode = 2'b11;
        end
      end
      1: if (out_room) begin
        put_out = 1; put_word = m_held; npend = 3; nvalid = 1; ncode = 2'b01;
      end
      2: begin
        if (in_have) begin
          take_in = 1; npend = 3; nvalid = 1; ncode = 2'b10; ndata = in_front;
        end else if (m_waited + 1 == TIMEOUT) begin
          npend = 3; nvalid = 1; ncode = 2'b11;
        end else begin
          m_waited++;
        end
      end
      default: npend = 0;
    endcase
    if (out_pop) void'(m_out_q.pop_front());
    if (put_out) m_out_q.push_back(put_word);
    if (take_in) void'(m_in_q.pop_front());
    if (in_push) m_in_q.push_back(hd);
    m_pending = npend;
    m_code    = ncode;
    m_data    = ndata;
    m_valid   = nvalid;
  endtask

  task automatic compare_all();
    check("rsp_code", {30'd0, from_peripheral}, {30'd0, m_code});
    check("rsp_data", from_peripheral_data, m_data);
    check("rsp_valid", {31'd0, from_peripheral_valid}, {31'd0, m_valid});
    check("out_valid", {31'd0, host_out_valid}, {31'd0, (m_out_q.size() > 0)});
    check("out_data", host_out_data, (m_out_q.size() > 0) ? m_out_q[0] : '0);
    check("in_ready", {31'd0, host_in_ready}, {31'd0, (m_in_q.size() < DEPTH)});
    check("overrun", {31'd0, overrun}, {31'd0, m_overrun});
  endtask

  // One clock: drive at the falling edge, model the rising edge, compare at the next falling edge.
  task automatic step(input logic [1:0] c, input logic v, input logic [DW-1:0] wd,
                      input logic rdy, input logic hv, input logic [DW-1:0] hd, input logic rst);
    reset               = rst;
    to_peripheral       = c;
    to_peripheral_valid = v;
    to_peripheral_data  = wd;
    host_out_ready      = rdy;
    host_in_valid       = hv;
    host_in_data        = hd;
    if (rst) model_reset();
    else     model_step(c, v, wd, rdy, hv, hd);
    @(posedge clock);
    @(negedge clock);
    compare_all();
    if (from_peripheral_valid)
      $display("txn rsp code=%0d data=%h host_out_level=%0d", from_peripheral, from_peripheral_data,
               m_out_q.size());
  endtask

  task automatic idle(input logic rdy);
    step(2'b00, 1'b0, '0, rdy, 1'b0, '0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    reset               = 1'b1;
    to_peripheral       = 2'b00;
    to_peripheral_valid = 1'b0;
    to_peripheral_data  = '0;
    host_out_ready      = 1'b0;
    host_in_valid       = 1'b0;
    host_in_data        = '0;
    model_reset();
    @(negedge clock);

    step(2'b00, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    step(2'b00, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    check("reset_in_ready", {31'd0, host_in_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, from_peripheral_valid}, 32'd0);

    // Write accept
    step(2'b01, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, '0, 1'b0);
    check("wr_accept_code", {30'd0, from_peripheral}, 32'd1);
    check("wr_accept_head", host_out_data, 32'hDEADBEEF);
    idle(1'b0);
    check("wr_accept_one_cycle", {31'd0, from_peripheral_valid}, 32'd0);
    idle(1'b1);

    // Read hit
    step(2'b00, 1'b0, '0, 1'b0, 1'b1, 32'h12345678, 1'b0);
    step(2'b10, 1'b1, '0, 1'b0, 1'b0, '0, 1'b0);
    check("rd_hit_code", {30'd0, from_peripheral}, 32'd2);
    check("rd_hit_data", from_peripheral_data, 32'h12345678);
    check("rd_hit_in_ready", {31'd0, host_in_ready}, 32'd1);
    idle(1'b0);

    // Full out FIFO stall, then release by one host pop
    for (int i = 0; i < DEPTH; i++) begin
      step(2'b01, 1'b1, DW'(i), 1'b0, 1'b0, '0, 1'b0);
      idle(1'b0);
    end
    step(2'b01, 1'b1, 32'd8, 1'b0, 1'b0, '0, 1'b0);
    check("stall_no_rsp", {31'd0, from_peripheral_valid}, 32'd0);
    idle(1'b0);
    check("stall_still_waiting", {31'd0, from_peripheral_valid}, 32'd0);
    check("drain_order", host_out_data, 32'd0);
    idle(1'b1);
    check("stall_ack", {30'd0, from_peripheral}, 32'd1);
    for (int i = 1; i <= DEPTH; i++) begin
      check("drain_order", host_out_data, DW'(i));
      idle(1'b1);
    end
    check("drain_empty", {31'd0, host_out_valid}, 32'd0);

    // Read timeout on an empty in FIFO
    step(2'b10, 1'b1, '0, 1'b0, 1'b0, '0, 1'b0);
    for (int k = 0; k < TIMEOUT; k++) begin
      check("timeout_wait", {31'd0, from_peripheral_valid}, 32'd0);
      idle(1'b0);
    end
    check("timeout_error", {30'd0, from_peripheral}, 32'd3);
    idle(1'b0);

    // Read satisfied by a host push during wait cycle 2 (lands on the timeout cycle)
    step(2'b10, 1'b1, '0, 1'b0, 1'b0, '0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    step(2'b00, 1'b0, '0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0);
    check("late_data_wait", {31'd0, from_peripheral_valid}, 32'd0);
    idle(1'b0);
    check("late_data_code", {30'd0, from_peripheral}, 32'd2);
    check("late_data_value", from_peripheral_data, 32'hCAFEF00D);
    idle(1'b0);

    // Overrun while a read is outstanding
    step(2'b10, 1'b1, '0, 1'b0, 1'b0, '0, 1'b0);
    step(2'b01, 1'b1, 32'h55, 1'b0, 1'b0, '0, 1'b0);
    check("overrun_set", {31'd0, overrun}, 32'd1);
    check("overrun_drop", {31'd0, host_out_valid}, 32'd0);
    for (int k = 0; k < TIMEOUT + 1; k++) idle(1'b0);

    // Reserved command
    step(2'b11, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, '0, 1'b0);
    check("rsvd_code", {30'd0, from_peripheral}, 32'd3);
    check("rsvd_data", from_peripheral_data, 32'd0);
    idle(1'b0);

    // Reset while a write is stalled
    for (int i = 0; i < DEPTH; i++) begin
      step(2'b01, 1'b1, 32'h100 + DW'(i), 1'b0, 1'b0, '0, 1'b0);
      idle(1'b0);
    end
    step(2'b01, 1'b1, 32'hAA, 1'b0, 1'b0, '0, 1'b0);
    step(2'b00, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    check("midreset_valid", {31'd0, from_peripheral_valid}, 32'd0);
    check("midreset_out_valid", {31'd0, host_out_valid}, 32'd0);
    check("midreset_overrun", {31'd0, overrun}, 32'd0);
    idle(1'b0);
    check("midreset_no_late_rsp", {31'd0, from_peripheral_valid}, 32'd0);
    step(2'b01, 1'b1, 32'hBB, 1'b0, 1'b0, '0, 1'b0);
    check("midreset_next_ack", {30'd0, from_peripheral}, 32'd1);
    check("midreset_next_head", host_out_data, 32'hBB);
    idle(1'b0);

    // Random traffic with phases of host back-pressure
    for (int n = 0; n < 1500; n++) begin
      logic [1:0]    c;
      logic          v;
      logic [DW-1:0] wd;
      logic          rdy;
      logic          hv;
      logic          rst;
      int            sel;
      sel = $urandom_range(0, 9);
      c   = (sel < 4) ? 2'b01 : (sel < 8) ? 2'b10 : (sel == 8) ? 2'b11 : 2'b00;
      v   = ($urandom_range(0, 2) == 0);
      wd  = $urandom;
      rdy = ((n / 150) % 2 == 0) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
      hv  = ((n / 100) % 3 == 0) ? 1'b0 : ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 399) == 0);
      step(c, v, wd, rdy, hv, $urandom, rst);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_peripheral_responder.md
Name: core_peripheral_responder

Overview:
- Responder end of the RISC_V_Core peripheral port.
- Consumes the core's to_peripheral command/data/valid and answers on from_peripheral/from_peripheral_data/from_peripheral_valid.
- Buffers core writes toward a host stream and serves core reads from a host input stream, both through FIFOs.
- Sits beside core0 in SoC tops and benches, replacing static tie-offs of the from_peripheral_* inputs.

Parameters:
- DATA_WIDTH, 32, width of the peripheral data path.
- OUT_DEPTH_BITS, 3, log2 depth of the core-to-host FIFO (8 entries).
- IN_DEPTH_BITS, 3, log2 depth of the host-to-core FIFO (8 entries).
- TIMEOUT, 255, cycles a pending read waits for host data before an error response; 0 disables the timeout.

Ports:
- clock  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high.
- to_peripheral  in  2  command from core: 00 none, 01 WRITE, 10 READ, 11 reserved.
- to_peripheral_data  in  DATA_WIDTH  WRITE payload.
- to_peripheral_valid  in  1  command strobe, one cycle.
- from_peripheral  out  2  response code: 00 none, 01 WR_ACK, 10 RD_DATA, 11 ERROR.
- from_peripheral_data  out  DATA_WIDTH  read data on RD_DATA, else 0.
- from_peripheral_valid  out  1  one-cycle response strobe.
- host_out_data  out  DATA_WIDTH  head of the core-to-host FIFO.
- host_out_valid  out  1  core-to-host FIFO not empty.
- host_out_ready  in  1  host pops when valid and ready.
- host_in_data  in  DATA_WIDTH  host-to-core word.
- host_in_valid  in  1  host push request.
- host_in_ready  out  1  host-to-core FIFO not full.
- overrun  out  1  sticky: a command arrived while a request was outstanding.

Behaviour:
- Reset:
  - All outputs 0, except host_in_ready, which is 1.
  - Both FIFOs empty; FSM in IDLE; timeout counter 0; overrun cleared.
- Reset asserted mid-request: the request is dropped with no response, and both FIFOs are flushed.
- FSM states: IDLE, WAIT_WR, WAIT_RD, RESP.
- IDLE, on to_peripheral_valid:
  - WRITE with out FIFO not full: push the data and go to RESP with WR_ACK. Response is valid on the next cycle (latency 1).
  - WRITE with out FIFO full: latch the data and go to WAIT_WR.
  - READ with in FIFO not empty: pop, register the word, and go to RESP with RD_DATA (latency 1).
  - READ with in FIFO empty: clear the counter and go to WAIT_RD.
  - Code 11 or 00 with valid: go to RESP with ERROR and data 0.
- WAIT_WR: on the first cycle the out FIFO has space, push the latched data and go to RESP with WR_ACK.
- WAIT_RD:
  - Counter increments each cycle.
  - The first cycle the in FIFO is non-empty, pop and go to RESP with RD_DATA.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT before data arrives, go to RESP with ERROR.
  - Data arriving on the same cycle as the timeout wins, giving RD_DATA.
- RESP: from_peripheral_valid=1 for exactly one cycle with the code and data; from_peripheral and from_peripheral_data return to 0 the next cycle. Return to IDLE.
- Busy rule: to_peripheral_valid in any non-IDLE state is ignored and sets overrun until reset. An IDLE command in the cycle immediately after RESP is accepted.
- FIFOs:
  - Synchronous, first-word-fall-through, pointer width depth_bits+1 with wrap.
  - Push and pop in the same cycle on a full FIFO is allowed for the out FIFO (host pop frees the slot) but not for the in FIFO; host_in_ready is strictly !full.
  - On an empty FIFO, a same-cycle push and pop yields no pop; data becomes visible the next cycle.
- Widths: data passes through unmodified with no sign or zero extension.

Decomposition:
- Shared package core_peripheral_pkg holds:
  - command codes CMD_NONE/CMD_WRITE/CMD_READ/CMD_RSVD;
  - response codes RSP_NONE/RSP_WR_ACK/RSP_RD_DATA/RSP_ERROR;
  - FSM state encoding.
- One sub-module: peripheral_fifo (parameters DATA_WIDTH, DEPTH_BITS; ports push/pop/full/empty/head), instantiated twice.

Test Plan:
- Write accept: reset, WRITE 0xDEADBEEF with host_out_ready=0.
  - Next cycle: from_peripheral=01, valid=1 for one cycle.
  - host_out_valid=1 and host_out_data=0xDEADBEEF.
- Read hit: host pushes 0x12345678, then core READ → next cycle from_peripheral=10, data=0x12345678; host_in_ready stays 1.
- Full FIFO stall: 8 WRITEs (0..7) with ready=0, then WRITE 0x8 → no response. Raise host_out_ready one cycle → WR_ACK follows; host drains 0..8 in order.
- Read wait and timeout (TIMEOUT=4):
  - READ on empty FIFO → ERROR after 4 wait cycles plus RESP.
  - Repeat with host push at wait cycle 2 → RD_DATA carrying the pushed word.
- Overrun and reserved:
  - READ on empty, then WRITE while in WAIT_RD → overrun=1, write dropped (host_out_valid stays 0).
  - Code 11 in IDLE → ERROR, data 0.
- Reset mid-request: enter WAIT_WR, assert reset one cycle → no response, outputs 0, host_out_valid=0, next WRITE acked normally.
